// File: rtl/ped_request_conditioner.sv
// Pedestrian button conditioner: sync, debounce, and a per-road
// request FSM (IDLE/PENDING/COOLDOWN) with press counting.
module ped_req_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned COOLDOWN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       serve,
  output logic       ped_button,
  output logic [3:0] press_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    COOL = 2'b10,
    BAD  = 2'b11
  } st_e;

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] CD_LD  = 8'(COOLDOWN_CYCLES);

  logic       s1_q, s2_q;
  logic       filt_q, filt_d;
  logic [3:0] db_q, db_d;
  logic       press;
  st_e        st_q, st_d;
  logic       ped_q, ped_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cd_q, cd_d;

  always_comb begin
    filt_d = filt_q;
    db_d   = '0;
    if (s2_q != filt_q) begin
      if (db_q + 4'd1 == DB_MAX) begin
        filt_d = ~filt_q;
      end else begin
        db_d = db_q + 4'd1;
      end
    end
    press = filt_d & ~filt_q;
  end

  always_comb begin
    st_d  = st_q;
    ped_d = ped_q;
    cnt_d = cnt_q;
    cd_d  = cd_q;
    case (st_q)
      IDLE: begin
        ped_d = 1'b0;
        cnt_d = '0;
        if (press) begin
          st_d  = PEND;
          ped_d = 1'b1;
          cnt_d = 4'd1;
        end
      end
      PEND: begin
        // serve wins over a coincident press
        if (serve) begin
          st_d  = (COOLDOWN_CYCLES == 0) ? IDLE : COOL;
          ped_d = 1'b0;
          cnt_d = '0;
          cd_d  = CD_LD;
        end else if (press && cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      COOL: begin
        cd_d = cd_q - 8'd1;
        if (cd_q <= 8'd1) begin
          st_d = IDLE;
          cd_d = '0;
        end
      end
      default: begin
        st_d  = IDLE;
        ped_d = 1'b0;
        cnt_d = '0;
        cd_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      db_q   <= '0;
      st_q   <= IDLE;
      ped_q  <= 1'b0;
      cnt_q  <= '0;
      cd_q   <= '0;
    end else begin
      s1_q   <= btn_raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      db_q   <= db_d;
      st_q   <= st_d;
      ped_q  <= ped_d;
      cnt_q  <= cnt_d;
      cd_q   <= cd_d;
    end
  end

  assign ped_button  = ped_q;
  assign press_count = cnt_q;
  assign state       = st_q;

endmodule

module ped_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned COOLDOWN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_A_raw,
  input  logic       btn_B_raw,
  input  logic       serve_A,
  input  logic       serve_B,
  output logic       ped_button_A,
  output logic       ped_button_B,
  output logic [3:0] press_count_A,
  output logic [3:0] press_count_B,
  output logic [3:0] chan_state
);

  logic [1:0] st_a, st_b;

  ped_req_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_A_raw),
    .serve      (serve_A),
    .ped_button (ped_button_A),
    .press_count(press_count_A),
    .state      (st_a)
  );

  ped_req_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_B_raw),
    .serve      (serve_B),
    .ped_button (ped_button_B),
    .press_count(press_count_B),
    .state      (st_b)
  );

  assign chan_state = {st_b, st_a};

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: directed scenarios plus
// random stimulus against a history-based reference model.
module tb_ped_request_conditioner;

  localparam int DB = 2;
  localparam int CD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_A_raw = 1'b0;
  logic       btn_B_raw = 1'b0;
  logic       serve_A = 1'b0;
  logic       serve_B = 1'b0;
  logic       ped_button_A, ped_button_B;
  logic [3:0] press_count_A, press_count_B;
  logic [3:0] chan_state;

  int pass_n = 0;
  int tot_n  = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_A_raw    (btn_A_raw),
    .btn_B_raw    (btn_B_raw),
    .serve_A      (serve_A),
    .serve_B      (serve_B),
    .ped_button_A (ped_button_A),
    .ped_button_B (ped_button_B),
    .press_count_A(press_count_A),
    .press_count_B(press_count_B),
    .chan_state   (chan_state)
  );

  always #5 clk = ~clk;

  // Model: filter flips once the last DB compared samples all disagree
  // with it and DB edges have passed since its previous flip.
  typedef struct {
    bit          s1;
    bit          s2;
    bit          filt;
    int          last_tog;
    logic [15:0] hist;
    int          st;
    int          cnt;
    int          cool_until;
  } ch_t;

  ch_t mA, mB;
  int  edge_n = 0;

  function automatic ch_t ch_reset();
    ch_t c;
    c.s1 = 0; c.s2 = 0; c.filt = 0;
    c.last_tog = -1000; c.hist = '0;
    c.st = 0; c.cnt = 0; c.cool_until = -1;
    return c;
  endfunction

  function automatic ch_t step(ch_t c, bit raw, bit srv, int t);
    ch_t n = c;
    bit press = 0;
    bit all_diff = 1;
    n.hist = {c.hist[14:0], c.s2};
    if (t - c.last_tog >= DB) begin
      for (int k = 0; k < DB; k++)
        if (n.hist[k] == c.filt) all_diff = 0;
      if (all_diff) begin
        n.filt = ~c.filt;
        n.last_tog = t;
        press = n.filt;
      end
    end
    n.s2 = c.s1;
    n.s1 = raw;
    case (c.st)
      0: if (press) begin n.st = 1; n.cnt = 1; end
      1: begin
        if (srv) begin
          n.cnt = 0;
          if (CD == 0) n.st = 0;
          else begin n.st = 2; n.cool_until = t + CD; end
        end else if (press && c.cnt < 15) n.cnt = c.cnt + 1;
      end
      default: if (t == c.cool_until) n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA <= ch_reset();
      mB <= ch_reset();
    end else begin
      mA <= step(mA, btn_A_raw, serve_A, edge_n);
      mB <= step(mB, btn_B_raw, serve_B, edge_n);
      edge_n <= edge_n + 1;
    end
  end

  function automatic logic [13:0] mdl_o();
    logic [1:0] sa = 2'(mA.st);
    logic [1:0] sb = 2'(mB.st);
    return {mA.st == 1, mB.st == 1, 4'(mA.cnt), 4'(mB.cnt), sb, sa};
  endfunction

  logic [13:0] dut_o;
  assign dut_o = {ped_button_A, ped_button_B, press_count_A,
                  press_count_B, chan_state};

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic press_btn(input bit ch);
    if (ch) btn_B_raw = 1; else btn_A_raw = 1;
    tick(4);
    if (ch) btn_B_raw = 0; else btn_A_raw = 0;
    tick(5);
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(3);
    tot_n++;
    if (dut_o !== 14'h0)
      $display("FAIL reset_outputs: got %h expected 0000", dut_o);
    else pass_n++;
    rst_n = 1;
    tick(2);
    tot_n++;
    if (dut_o !== 14'h0)
      $display("FAIL reset_release_idle: got %h expected 0000", dut_o);
    else pass_n++;
  endtask

  task automatic test_press_a();
    btn_A_raw = 1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      tot_n++;
      if (ped_button_A !== (e >= 4))
        $display("FAIL pressA_edge%0d: got %b expected %b",
                 e, ped_button_A, e >= 4);
      else pass_n++;
    end
    tot_n++;
    if ({press_count_A, chan_state, ped_button_B, press_count_B}
        !== {4'd1, 4'b0001, 1'b0, 4'd0})
      $display("FAIL pressA_state: cnt %0d st %b pedB %b cntB %0d",
               press_count_A, chan_state, ped_button_B, press_count_B);
    else pass_n++;
    btn_A_raw = 0;
    tick(6);
  endtask

  task automatic test_glitch_b();
    bit pat [9] = '{1, 0, 0, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      btn_B_raw = pat[i];
      tick();
    end
    btn_B_raw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tot_n++;
      if ({ped_button_B, press_count_B, chan_state[3:2]} !== 7'b0)
        $display("FAIL glitchB_c%0d: ped %b cnt %0d st %b expected 0",
                 i, ped_button_B, press_count_B, chan_state[3:2]);
      else pass_n++;
    end
  endtask

  task automatic test_serve_b();
    for (int i = 1; i <= 5; i++) begin
      press_btn(1);
      tot_n++;
      if (press_count_B !== 4'(i) || ped_button_B !== 1'b1)
        $display("FAIL serveB_press%0d: cnt %0d ped %b expected %0d 1",
                 i, press_count_B, ped_button_B, i);
      else pass_n++;
    end
    serve_B = 1;
    tick();
    serve_B = 0;
    tot_n++;
    if ({ped_button_B, press_count_B, chan_state[3:2]} !== 7'b0000010)
      $display("FAIL serveB_clear: ped %b cnt %0d st %b expected 0 0 10",
               ped_button_B, press_count_B, chan_state[3:2]);
    else pass_n++;
    btn_B_raw = 1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) btn_B_raw = 0;
      tick();
      tot_n++;
      if (ped_button_B !== 1'b0 || press_count_B !== 4'd0 ||
          chan_state[3:2] !== ((k < 10) ? 2'b10 : 2'b00))
        $display("FAIL serveB_cool_k%0d: ped %b cnt %0d st %b",
                 k, ped_button_B, press_count_B, chan_state[3:2]);
      else pass_n++;
    end
  endtask

  task automatic test_collide_a();
    btn_A_raw = 1;
    tick(3);
    serve_A = 1;
    tick();
    serve_A = 0;
    tot_n++;
    if ({ped_button_A, press_count_A, chan_state[1:0]} !== 7'b0000010)
      $display("FAIL collideA: ped %b cnt %0d st %b expected 0 0 10",
               ped_button_A, press_count_A, chan_state[1:0]);
    else pass_n++;
    btn_A_raw = 0;
    tick(12);
    tot_n++;
    if (chan_state[1:0] !== 2'b00)
      $display("FAIL collideA_idle: st %b expected 00", chan_state[1:0]);
    else pass_n++;
  endtask

  task automatic test_saturate_reset();
    for (int i = 1; i <= 20; i++) begin
      press_btn(0);
      tot_n++;
      if (press_count_A !== 4'((i > 15) ? 15 : i))
        $display("FAIL satA_press%0d: got %0d expected %0d",
                 i, press_count_A, (i > 15) ? 15 : i);
      else pass_n++;
    end
    serve_A = 1;
    tick();
    serve_A = 0;
    tick(3);
    tot_n++;
    if (chan_state[1:0] !== 2'b10)
      $display("FAIL satA_cool: st %b expected 10", chan_state[1:0]);
    else pass_n++;
    btn_A_raw = 1;
    #2 rst_n = 0;
    #1;
    tot_n++;
    if (dut_o !== 14'h0)
      $display("FAIL async_reset: got %h expected 0000", dut_o);
    else pass_n++;
    tick(2);
    rst_n = 1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      tot_n++;
      if (ped_button_A !== (e >= 4))
        $display("FAIL post_reset_edge%0d: got %b expected %b",
                 e, ped_button_A, e >= 4);
      else pass_n++;
    end
    btn_A_raw = 0;
    serve_A = 1;
    tick();
    serve_A = 0;
    tick(14);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) btn_A_raw = ~btn_A_raw;
      if ($urandom_range(5) == 0) btn_B_raw = ~btn_B_raw;
      serve_A = ($urandom_range(19) == 0);
      serve_B = ($urandom_range(19) == 0);
      tick();
      tot_n++;
      if (dut_o !== mdl_o()) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random_c%0d: got %h expected %h",
                   i, dut_o, mdl_o());
      end else pass_n++;
    end
    serve_A = 0;
    serve_B = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press_a();
    test_glitch_b();
    test_serve_b();
    test_collide_a();
    test_saturate_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/ped_request_conditioner.md
PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2: consecutive cycles a synchronized button level must differ from its filtered level before the filtered level changes; legal range 1..15.
REQ-002 Parameter COOLDOWN_CYCLES, default 10: cycles after a serve during which new presses on that road are ignored; legal range 0..255.
REQ-003 Port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port btn_A_raw, input, 1 bit: asynchronous pedestrian button for road A, active-high, may bounce.
REQ-006 Port btn_B_raw, input, 1 bit: as btn_A_raw, for road B.
REQ-007 Port serve_A, input, 1 bit: synchronous pulse from the traffic controller; the road A crossing request has been honoured.
REQ-008 Port serve_B, input, 1 bit: as serve_A, for road B.
REQ-009 Port ped_button_A, output, 1 bit: registered level request to the traffic controller; high while the road A request is pending.
REQ-010 Port ped_button_B, output, 1 bit: as ped_button_A, for road B.
REQ-011 Port press_count_A, output, 4 bits: registered saturating count of accepted road A presses since the last serve.
REQ-012 Port press_count_B, output, 4 bits: as press_count_A, for road B.
REQ-013 Port chan_state, output, 4 bits: [1:0] road A FSM state, [3:2] road B FSM state; encoding IDLE=00, PENDING=01, COOLDOWN=10.

Function
REQ-014 Channels A and B shall be identical and fully independent; there shall be no cross-coupling.
REQ-015 Each raw button shall pass through a two-flop synchronizer before any other logic.
REQ-016 Debounce: a counter shall count cycles where the synchronized level differs from the filtered level, clear to 0 on any cycle they match, and toggle the filtered level and clear itself on the cycle the count reaches DEBOUNCE_CYCLES.
REQ-017 A press event shall be defined as the edge on which the filtered level changes 0->1; release (1->0) shall generate no event.
REQ-018 A raw level change held steadily shall produce a press event on rising edge 2+DEBOUNCE_CYCLES after it is first sampled; any synchronized pulse shorter than DEBOUNCE_CYCLES cycles shall produce no event.
REQ-019 FSM IDLE: a press event shall move the channel to PENDING and assert ped_button on that same edge; serve shall be ignored.
REQ-020 FSM PENDING: ped_button shall stay high; further press events shall only increment press_count.
REQ-021 FSM PENDING: serve shall move the channel to COOLDOWN, clear ped_button and press_count, and load the cooldown counter with COOLDOWN_CYCLES.
REQ-022 If serve and a press event coincide in PENDING, serve shall win and the press shall be dropped (count stays 0).
REQ-023 FSM COOLDOWN: press events and serve shall be ignored; the counter shall decrement each cycle, and the channel shall move to IDLE on the edge where the counter is 1.
REQ-024 If COOLDOWN_CYCLES=0, serve in PENDING shall move the channel directly to IDLE.
REQ-025 A press event on the edge that leaves COOLDOWN shall be ignored.
REQ-026 press_count shall increment by 1 per accepted press event (including the one entering PENDING) and saturate at 15.
REQ-027 Unused state encoding 11 shall recover to IDLE on the next edge.

Reset
REQ-028 With rst_n low, all of the following shall clear immediately and hold: synchronizers, filtered levels, debounce and cooldown counters, ped_button_A/B=0, press_count_A/B=0, chan_state=0000.
REQ-029 Reset asserted mid-PENDING or mid-COOLDOWN shall discard the request; after release, a held button shall need a full 2+DEBOUNCE_CYCLES to register.

Verification
REQ-030 Defaults; btn_A_raw held high 5 cycles -> ped_button_A rises on edge 4, press_count_A=1, chan_state[1:0]=01; road B unaffected.
REQ-031 Defaults; btn_B_raw 1-cycle glitch, then a 3-cycle bounce train 1,0,1 -> no ped_button_B, press_count_B=0.
REQ-032 Defaults; five clean debounced presses on B while PENDING, then serve_B pulse -> press_count_B reaches 5, then 0 and ped_button_B=0 on the serve edge; a press during the next 10 cycles is ignored.
REQ-033 Press event and serve_A on the same edge in PENDING -> state COOLDOWN, press_count_A=0, ped_button_A=0.
REQ-034 Twenty presses without serve -> press_count saturates at 15; rst_n pulsed low mid-COOLDOWN -> all outputs 0 asynchronously.
